fwd_ctrl: RTL and testbench

- Forwarding and load-use hazard controller for the 5-stage MIPS pipeline; produces the `fa`/`fb` selects consumed by the ALU input muxes.
- Keeps its own shadow pipeline of destination-register info:
  - ID/EX: op, rs, rt, dest, regwrite, isload.
  - EX/MEM: dest, regwrite, isload.
  - MEM/WB: dest, regwrite.
- Shadow stages are loaded from the instruction leaving IF/ID.
- From these it generates the select codes, a one-cycle load-use stall, and a saturating stall counter.

---
 rtl/fwd_ctrl.sv | 154 +++++++++++++++
 tb/tb_fwd_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: ALU operand forwarding selects and load-use stall control for a 5-stage MIPS pipeline.
// Keeps a shadow copy of the destination info in ID/EX, EX/MEM and MEM/WB.
module fwd_ctrl #(
  parameter logic [5:0]  OP_ALU  = 6'd0,
  parameter logic [5:0]  OP_LW   = 6'd35,
  parameter logic [5:0]  OP_SW   = 6'd43,
  parameter logic [5:0]  OP_ADDI = 6'd8,
  parameter logic [5:0]  OP_J    = 6'd2,
  parameter logic [5:0]  OP_JAL  = 6'd3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ifid_ir,
  input  logic             flush,
  output logic [1:0]       fa,
  output logic [1:0]       fb,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [5:0]       idex_op,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       regwrite;
    logic       isload;
    logic       uses_rs;
    logic       uses_rt;
  } stage_t;

  localparam stage_t Bubble = {6'h3F, 19'd0};

  stage_t           dec;
  stage_t           idex_d, idex_q;
  logic [4:0]       exmem_dest_d, exmem_dest_q;
  logic             exmem_rw_d, exmem_rw_q;
  logic             exmem_ld_d, exmem_ld_q;
  logic [4:0]       memwb_dest_d, memwb_dest_q;
  logic             memwb_rw_d, memwb_rw_q;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;
  logic             unused_ir;

  assign unused_ir = ^ifid_ir[10:0];

  always_comb begin
    dec    = Bubble;
    dec.op = ifid_ir[31:26];
    dec.rs = ifid_ir[25:21];
    dec.rt = ifid_ir[20:16];
    case (dec.op)
      OP_ALU: begin
        dec.dest     = ifid_ir[15:11];
        dec.regwrite = 1'b1;
        dec.uses_rs  = 1'b1;
        dec.uses_rt  = 1'b1;
      end
      OP_LW: begin
        dec.dest     = ifid_ir[20:16];
        dec.regwrite = 1'b1;
        dec.isload   = 1'b1;
        dec.uses_rs  = 1'b1;
      end
      OP_SW: begin
        dec.uses_rs = 1'b1;
        dec.uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec.dest     = ifid_ir[20:16];
        dec.regwrite = 1'b1;
        dec.uses_rs  = 1'b1;
      end
      OP_JAL: begin
        dec.dest     = 5'd31;
        dec.regwrite = 1'b1;
      end
      OP_J:    ;
      default: ;
    endcase
  end

  // A load in EX/MEM has no data yet, so it is skipped and MEM/WB gets a chance.
  function automatic logic [1:0] fwd_sel(input logic       used,
                                         input logic [4:0] src,
                                         input logic       em_rw,
                                         input logic       em_ld,
                                         input logic [4:0] em_dest,
                                         input logic       mw_rw,
                                         input logic [4:0] mw_dest);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && em_rw && !em_ld && em_dest != 5'd0 && em_dest == src) begin
      sel = 2'b10;
    end else if (used && mw_rw && mw_dest != 5'd0 && mw_dest == src) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fa = fwd_sel(idex_q.uses_rs, idex_q.rs, exmem_rw_q, exmem_ld_q, exmem_dest_q,
                 memwb_rw_q, memwb_dest_q);
    fb = fwd_sel(idex_q.uses_rt, idex_q.rt, exmem_rw_q, exmem_ld_q, exmem_dest_q,
                 memwb_rw_q, memwb_dest_q);
  end

  always_comb begin
    stall = idex_q.isload && idex_q.dest != 5'd0 &&
            ((dec.uses_rs && dec.rs == idex_q.dest) ||
             (dec.uses_rt && dec.rt == idex_q.dest));
    pc_write    = ~stall;
    ifid_write  = ~stall;
    idex_op     = idex_q.op;
    stall_count = stall_count_q;
  end

  always_comb begin
    idex_d        = (flush || stall) ? Bubble : dec;
    exmem_dest_d  = idex_q.dest;
    exmem_rw_d    = idex_q.regwrite;
    exmem_ld_d    = idex_q.isload;
    memwb_dest_d  = exmem_dest_q;
    memwb_rw_d    = exmem_rw_q;
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != {CNT_W{1'b1}}) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idex_q        <= Bubble;
      exmem_dest_q  <= '0;
      exmem_rw_q    <= 1'b0;
      exmem_ld_q    <= 1'b0;
      memwb_dest_q  <= '0;
      memwb_rw_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      idex_q        <= idex_d;
      exmem_dest_q  <= exmem_dest_d;
      exmem_rw_q    <= exmem_rw_d;
      exmem_ld_q    <= exmem_ld_d;
      memwb_dest_q  <= memwb_dest_d;
      memwb_rw_q    <= memwb_rw_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: directed vector table, then random instruction streams against a
// pipeline-occupancy model; a narrow-counter instance exercises stall_count saturation.
module tb_fwd_ctrl;

  localparam logic [31:0] BubIr = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] ifid_ir;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        stall, pc_write, ifid_write, stall4, pc_write4, ifid_write4;
  logic [5:0]  idex_op, idex_op4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fwd_ctrl u_dut (
    .clock      (clock),
    .reset      (reset),
    .ifid_ir    (ifid_ir),
    .flush      (flush),
    .fa         (fa),
    .fb         (fb),
    .stall      (stall),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .idex_op    (idex_op),
    .stall_count(stall_count)
  );

  fwd_ctrl #(.CNT_W(4)) u_dut4 (
    .clock      (clock),
    .reset      (reset),
    .ifid_ir    (ifid_ir),
    .flush      (flush),
    .fa         (fa4),
    .fb         (fb4),
    .stall      (stall4),
    .pc_write   (pc_write4),
    .ifid_write (ifid_write4),
    .idex_op    (idex_op4),
    .stall_count(stall_count4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [1:0] e_fa, input logic [1:0] e_fb, input logic e_st,
                           input logic [5:0] e_op, input int e_cnt);
    int c4;
    c4 = (e_cnt > 15) ? 15 : e_cnt;
    chk("fa", 32'(fa), 32'(e_fa));
    chk("fb", 32'(fb), 32'(e_fb));
    chk("stall", 32'(stall), 32'(e_st));
    chk("pc_write", 32'(pc_write), 32'(!e_st));
    chk("ifid_write", 32'(ifid_write), 32'(!e_st));
    chk("idex_op", 32'(idex_op), 32'(e_op));
    chk("stall_count", 32'(stall_count), 32'(e_cnt));
    chk("fa_w4", 32'(fa4), 32'(e_fa));
    chk("fb_w4", 32'(fb4), 32'(e_fb));
    chk("stall_w4", 32'(stall4 & ~pc_write4 & ~ifid_write4 | (stall4 ^ e_st)), 32'(e_st));
    chk("idex_op_w4", 32'(idex_op4), 32'(e_op));
    chk("stall_count_w4", 32'(stall_count4), 32'(c4));
  endtask

  // Reference model: the three in-flight instruction words (EX, MEM, WB) as raw encodings.
  function automatic logic [4:0] m_dest(input logic [31:0] ir);
    case (ir[31:26])
      6'd0:        return ir[15:11];
      6'd35, 6'd8: return ir[20:16];
      6'd3:        return 5'd31;
      default:     return 5'd0;
    endcase
  endfunction

  // An unused source is reported as $0, which can never match a real producer.
  function automatic logic [4:0] m_rs(input logic [31:0] ir);
    case (ir[31:26])
      6'd0, 6'd35, 6'd43, 6'd8: return ir[25:21];
      default:                  return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] m_rt(input logic [31:0] ir);
    case (ir[31:26])
      6'd0, 6'd43: return ir[20:16];
      default:     return 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] src, input logic [31:0] mem,
                                       input logic [31:0] wb);
    if (src == 5'd0) return 2'b00;
    if (mem[31:26] != 6'd35 && m_dest(mem) == src) return 2'b10;
    if (m_dest(wb) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall(input logic [31:0] ex, input logic [31:0] ir);
    logic [4:0] d;
    d = m_dest(ex);
    return ex[31:26] == 6'd35 && d != 5'd0 && (m_rs(ir) == d || m_rt(ir) == d);
  endfunction

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd2;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0:       op = 6'd0;
      1:       op = 6'd35;
      2:       op = 6'd43;
      3:       op = 6'd8;
      4:       op = 6'd2;
      5:       op = 6'd3;
      default: op = 6'd5;
    endcase
    return {op, rreg(), rreg(), rreg(), 11'($urandom)};
  endfunction

  typedef struct {
    logic        rst;
    logic        fl;
    logic [31:0] ir;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [5:0]  op;
    int          cnt;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] ex, mem, wb, cur_ir;
    int          cnt;
    logic        s, prev_s;

    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 6'h3F, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    // ADD $5,$1,$1 then SUB $6,$5,$5
    tbl.push_back('{1'b0, 1'b0, 32'h0021_2820, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h00A5_3022, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd2, 2'd2, 1'b0, 6'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    // LW $2,0($1) then ADD $3,$2,$4: one stall, then MEM/WB forward on A
    tbl.push_back('{1'b0, 1'b0, 32'h8C22_0000, 2'd0, 2'd0, 1'b0, 6'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0044_1820, 2'd0, 2'd0, 1'b1, 6'h23, 0});
    tbl.push_back('{1'b0, 1'b0, 32'h0044_1820, 2'd0, 2'd0, 1'b0, 6'h3F, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd1, 2'd0, 1'b0, 6'h00, 1});
    // ADD $2,$1,$1; ADD $2,$3,$3; ADD $4,$2,$2: youngest producer wins
    tbl.push_back('{1'b0, 1'b0, 32'h0021_1020, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0063_1020, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0042_2020, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd2, 2'd2, 1'b0, 6'h00, 1});
    // Writes to $0 never forward, loads to $0 never stall
    tbl.push_back('{1'b0, 1'b0, 32'h0021_0020, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_2020, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h8C20_0000, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_1820, 2'd0, 2'd0, 1'b0, 6'h23, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    // Flush coinciding with a load-use stall
    tbl.push_back('{1'b0, 1'b0, 32'h8C22_0000, 2'd0, 2'd0, 1'b0, 6'h00, 1});
    tbl.push_back('{1'b0, 1'b1, 32'h0044_1820, 2'd0, 2'd0, 1'b1, 6'h23, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0044_1820, 2'd0, 2'd0, 1'b0, 6'h3F, 2});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 2'd1, 2'd0, 1'b0, 6'h00, 2});
    // Reset during a stall drops the hazard and clears the counter
    tbl.push_back('{1'b0, 1'b0, 32'h8C22_0000, 2'd0, 2'd0, 1'b0, 6'h00, 2});
    tbl.push_back('{1'b1, 1'b0, 32'h0044_1820, 2'd0, 2'd0, 1'b1, 6'h23, 2});
    tbl.push_back('{1'b0, 1'b0, 32'h0044_1820, 2'd0, 2'd0, 1'b0, 6'h3F, 0});

    reset   = 1'b1;
    flush   = 1'b0;
    ifid_ir = 32'h0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst;
      flush   = tbl[i].fl;
      ifid_ir = tbl[i].ir;
      #1;
      check_all(tbl[i].fa, tbl[i].fb, tbl[i].st, tbl[i].op, tbl[i].cnt);
      @(posedge clock);
      #1;
    end

    // Random phase: first cycle is a reset so the model starts aligned.
    ex     = BubIr;
    mem    = BubIr;
    wb     = BubIr;
    cnt    = 0;
    prev_s = 1'b0;
    cur_ir = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!prev_s) cur_ir = rand_ir();
      reset   = (i == 0) || ($urandom_range(0, 399) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      ifid_ir = cur_ir;
      #1;
      s = m_stall(ex, cur_ir);
      if (i != 0) begin
        check_all(m_sel(m_rs(ex), mem, wb), m_sel(m_rt(ex), mem, wb), s, ex[31:26], cnt);
      end
      if (reset) begin
        ex  = BubIr;
        mem = BubIr;
        wb  = BubIr;
        cnt = 0;
        s   = 1'b0;
      end else begin
        if (s && cnt < 65535) cnt++;
        wb  = mem;
        mem = ex;
        ex  = (flush || s) ? BubIr : cur_ir;
      end
      prev_s = s;
      @(posedge clock);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
